alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 22 ++
 rtl/alu_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for alu_arbiter: ALU function codes and arbiter FSM state encodings.
package alu_arbiter_pkg;

    localparam logic [5:0] ALU_ADD = 6'h00;
    localparam logic [5:0] ALU_SUB = 6'h01;
    localparam logic [5:0] ALU_AND = 6'h02;
    localparam logic [5:0] ALU_OR  = 6'h03;
    localparam logic [5:0] ALU_XOR = 6'h04;
    localparam logic [5:0] ALU_MUL = 6'h05;
    localparam logic [5:0] ALU_DIV = 6'h06;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_EXEC = 2'b01,
        ARB_RESP = 2'b10
    } arb_state_e;

    function automatic logic is_muldiv(input logic [5:0] fn);
        return (fn == ALU_MUL) || (fn == ALU_DIV);
    endfunction

endpackage

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// Define ALU_ARB_MULDIV_MC_EN to hold MUL/DIV in EXEC for MULDIV_CYCLES cycles.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [5:0]  req0_fn,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_y,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [5:0]  req1_fn,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_y,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_fn,
    input  logic [31:0] alu_y
);

    if ((MULDIV_CYCLES < 2) || (MULDIV_CYCLES > 15)) begin : g_bad_cfg
        $error("alu_arbiter: MULDIV_CYCLES must be within 2..15");
    end

    arb_state_e  r_state;
    logic        r_last_grant;
    logic        r_grant;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [5:0]  r_fn;
    logic [31:0] r_result;

    logic        w_pick;
    logic        w_accept;
    logic        w_rsp_fire;
    logic        w_exec_last;
    logic [31:0] w_a_sel;
    logic [31:0] w_b_sel;
    logic [5:0]  w_fn_sel;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        w_pick = 1'b0;
        if (req0_valid && req1_valid) begin
            w_pick = ~r_last_grant;
        end else if (req1_valid) begin
            w_pick = 1'b1;
        end else begin
            w_pick = 1'b0;
        end
    end

    // Operand mux feeding the latch registers on accept.
    always_comb begin
        w_a_sel  = 32'd0;
        w_b_sel  = 32'd0;
        w_fn_sel = 6'd0;
        if (w_pick) begin
            w_a_sel  = req1_a;
            w_b_sel  = req1_b;
            w_fn_sel = req1_fn;
        end else begin
            w_a_sel  = req0_a;
            w_b_sel  = req0_b;
            w_fn_sel = req0_fn;
        end
    end

    assign w_accept   = (r_state == ARB_IDLE) && (req0_valid || req1_valid);
    assign w_rsp_fire = (r_state == ARB_RESP) && (r_grant ? rsp1_ready : rsp0_ready);

`ifdef ALU_ARB_MULDIV_MC_EN
    logic [3:0] r_cnt;

    // EXEC occupancy down-counter; zero marks the final EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= is_muldiv(w_fn_sel) ? 4'(MULDIV_CYCLES - 1) : 4'd0;
        end else if ((r_state == ARB_EXEC) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign w_exec_last = (r_cnt == 4'd0);
`else
    assign w_exec_last = 1'b1;
`endif

    // Transaction FSM: grant and latch, execute, then hold the result until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_a          <= 32'd0;
            r_b          <= 32'd0;
            r_fn         <= 6'd0;
            r_result     <= 32'd0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_accept) begin
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                        r_a          <= w_a_sel;
                        r_b          <= w_b_sel;
                        r_fn         <= w_fn_sel;
                        r_state      <= ARB_EXEC;
                    end else begin
                        r_state      <= ARB_IDLE;
                    end
                end
                ARB_EXEC: begin
                    if (w_exec_last) begin
                        r_result <= alu_y;
                        r_state  <= ARB_RESP;
                    end else begin
                        r_state  <= ARB_EXEC;
                    end
                end
                ARB_RESP: begin
                    if (w_rsp_fire) begin
                        r_state <= ARB_IDLE;
                    end else begin
                        r_state <= ARB_RESP;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Ready is gated by rst_n so every output reads low while reset is held.
    assign req0_ready = rst_n && w_accept && !w_pick && req0_valid;
    assign req1_ready = rst_n && w_accept &&  w_pick && req1_valid;

    assign rsp0_valid = (r_state == ARB_RESP) && !r_grant;
    assign rsp1_valid = (r_state == ARB_RESP) &&  r_grant;
    assign rsp0_y     = rsp0_valid ? r_result : 32'd0;
    assign rsp1_y     = rsp1_valid ? r_result : 32'd0;

    assign alu_a  = r_a;
    assign alu_b  = r_b;
    assign alu_fn = r_fn;

endmodule
